// File: rtl/game_tick_gen.sv
// game_tick_gen - programmable game-timing tick generator.
//
// Emits a one-cycle tick every `period` clocks while running. The period
// shrinks by STEP per speed level, never below MIN_PERIOD. A slow tick fires
// on every SLOW_DIV-th tick. A free-running frame counter counts ticks.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   enable     1 = run, 0 = idle (period counter held cleared)
//   pause      1 = freeze counter and suppress ticks while enabled
//   speed_up   pulse: level + 1, saturating at MAX_LEVEL
//   speed_clr  pulse: level <- 0 (wins over speed_up)
//   tick       registered one-cycle game tick
//   slow_tick  registered pulse on every SLOW_DIV-th tick
//   level      current speed level
//   tick_count ticks since reset, wraps modulo 2^FRAME_W
//   period     period currently in use
//
// The period register is WIDTH bits wide. A period of exactly 2^WIDTH is
// held as 0. The wrap compare (cnt == period - 1) is done modulo 2^WIDTH,
// so that value still yields 2^WIDTH cycles between ticks.
module game_tick_gen #(
  parameter int WIDTH       = 18,
  parameter int BASE_PERIOD = 262144,
  parameter int STEP        = 16384,
  parameter int MIN_PERIOD  = 65536,
  parameter int MAX_LEVEL   = 7,
  parameter int LEVEL_W     = 3,
  parameter int SLOW_DIV    = 8,
  parameter int FRAME_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               pause,
  input  logic               speed_up,
  input  logic               speed_clr,
  output logic               tick,
  output logic               slow_tick,
  output logic [LEVEL_W-1:0] level,
  output logic [FRAME_W-1:0] tick_count,
  output logic [WIDTH-1:0]   period
);

  // Extra LEVEL_W bits keep level*STEP from overflowing.
  localparam int PW     = WIDTH + LEVEL_W;
  localparam int SLOW_W = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;

  localparam logic [PW-1:0]      BASE_EXT = PW'(BASE_PERIOD);
  localparam logic [PW-1:0]      MIN_EXT  = PW'(MIN_PERIOD);
  localparam logic [PW-1:0]      STEP_EXT = PW'(STEP);
  localparam logic [PW-1:0]      SPAN_EXT = PW'(BASE_PERIOD - MIN_PERIOD);
  localparam logic [SLOW_W-1:0]  SLOW_TOP = SLOW_W'(SLOW_DIV - 1);
  localparam logic [LEVEL_W-1:0] LVL_TOP  = LEVEL_W'(MAX_LEVEL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   cnt_reg, cnt_next;
  logic [WIDTH-1:0]   period_reg, period_next;
  logic               tick_reg, tick_next;
  logic               slow_reg, slow_next;
  logic [SLOW_W-1:0]  slow_cnt_reg, slow_cnt_next;
  logic [LEVEL_W-1:0] level_reg, level_next;
  logic [FRAME_W-1:0] frame_reg, frame_next;

  logic [PW-1:0]      level_step;
  logic [PW-1:0]      target_ext;
  logic [WIDTH-1:0]   target;
  logic               wrap;

  // Target period from the registered level. Clamping before the
  // subtraction means the subtraction can never underflow.
  assign level_step = PW'(level_reg) * STEP_EXT;
  assign target_ext = (level_step >= SPAN_EXT) ? MIN_EXT : (BASE_EXT - level_step);
  assign target     = target_ext[WIDTH-1:0];

  assign wrap = (cnt_reg == (period_reg - WIDTH'(1)));

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    period_next   = period_reg;
    tick_next     = 1'b0;
    slow_next     = 1'b0;
    slow_cnt_next = slow_cnt_reg;
    frame_next    = frame_reg;

    // Work done at this edge depends on the state being left.
    case (state_reg)
      IDLE: begin
        cnt_next    = '0;
        period_next = target;
      end
      RUN: begin
        if (wrap) begin
          cnt_next    = '0;
          tick_next   = 1'b1;
          frame_next  = frame_reg + FRAME_W'(1);
          period_next = target;
          if (slow_cnt_reg == SLOW_TOP) begin
            slow_cnt_next = '0;
            slow_next     = 1'b1;
          end else begin
            slow_cnt_next = slow_cnt_reg + SLOW_W'(1);
          end
        end else begin
          cnt_next = cnt_reg + WIDTH'(1);
        end
      end
      PAUSE: begin
        // Count, period and slow divider all hold.
      end
      default: begin
        cnt_next = '0;
      end
    endcase

    if (!enable) begin
      state_next = IDLE;
    end else if (pause) begin
      state_next = PAUSE;
    end else begin
      state_next = RUN;
    end
  end

  // Level changes in every state. Clear takes priority over speed-up.
  always_comb begin
    level_next = level_reg;
    if (speed_clr) begin
      level_next = '0;
    end else if (speed_up && (level_reg != LVL_TOP)) begin
      level_next = level_reg + LEVEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      period_reg   <= BASE_EXT[WIDTH-1:0];
      tick_reg     <= 1'b0;
      slow_reg     <= 1'b0;
      slow_cnt_reg <= '0;
      level_reg    <= '0;
      frame_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      period_reg   <= period_next;
      tick_reg     <= tick_next;
      slow_reg     <= slow_next;
      slow_cnt_reg <= slow_cnt_next;
      level_reg    <= level_next;
      frame_reg    <= frame_next;
    end
  end

  assign tick       = tick_reg;
  assign slow_tick  = slow_reg;
  assign level      = level_reg;
  assign tick_count = frame_reg;
  assign period     = period_reg;

endmodule
